iob_cache_be_mem: RTL and testbench

IOB_CACHE_BE_MEM -- requirements
Module: iob_cache_be_mem

---
 rtl/iob_cache_be_mem.sv | 105 ++++++++++
 tb/tb_iob_cache_be_mem.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/iob_cache_be_mem.sv
// Behavioural backing memory for a cache back-end, with a configurable response latency.
// Define BE_MEM_RAND_DELAY_EN to add an LFSR-driven random extra delay of 0..7 cycles per request.
module iob_cache_be_mem #(
    parameter int BE_ADDR_W  = 32,
    parameter int BE_DATA_W  = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    input  logic [BE_ADDR_W-1:0]   mem_addr,
    input  logic [BE_DATA_W-1:0]   mem_wdata,
    input  logic [BE_DATA_W/8-1:0] mem_wstrb,
    output logic [BE_DATA_W-1:0]   mem_rdata,
    output logic                   mem_ready
);
    localparam int NB        = BE_DATA_W / 8;
    localparam int BE_BYTE_W = $clog2(NB);
    localparam int DEPTH     = 1 << MEM_ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    accept, done;
    logic [4:0]              cnt, delay_ld;
    logic [MEM_ADDR_W-1:0]   req_idx;
    logic [BE_DATA_W-1:0]    req_wdata;
    logic [NB-1:0]           req_wstrb;
    logic [BE_DATA_W-1:0]    mem [DEPTH];

    // Address bits outside the word index are intentionally dropped (aliasing).
    logic unused_addr;
    assign unused_addr = ^mem_addr;

`ifdef BE_MEM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Current LFSR value sets this request's delay; the register then steps once.
    assign delay_ld = 5'(LATENCY) + {2'b00, lfsr[2:0]};

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 8'hA5;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`else
    assign delay_ld = 5'(LATENCY);
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (mem_valid) begin
                accept    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (cnt == 5'd0) begin
                done      = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_ready <= done;
            if (accept) begin
                cnt       <= delay_ld;
                req_idx   <= mem_addr[BE_BYTE_W +: MEM_ADDR_W];
                req_wdata <= mem_wdata;
                req_wstrb <= mem_wstrb;
            end else if (state == WAIT && cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
            // Read data is captured as the request completes and held across writes.
            if (done && req_wstrb == '0)
                mem_rdata <= mem[req_idx];
        end
    end

    // Storage is not reset; a write commits only on completion so a reset in WAIT drops it.
    always_ff @(posedge clk) begin
        if (!reset && done) begin
            for (int b = 0; b < NB; b++)
                if (req_wstrb[b])
                    mem[req_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
    end

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Scoreboard bench for iob_cache_be_mem: stimulus pushes expected responses, a monitor checks them.
module tb_iob_cache_be_mem;
`ifdef BE_MEM_RAND_DELAY_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    iob_cache_be_mem #(
        .BE_ADDR_W(32), .BE_DATA_W(32), .MEM_ADDR_W(10), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rd = '0;
    logic [7:0]  tb_lfsr = 8'hA5;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && mem_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready cyc=%0d got ready=1 want no response", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ready_cycle got=%0d want=%0d", cyc, e.cyc);
                end
                total++;
                if (mem_rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL rdata got=%h want=%h", mem_rdata, e.rdata);
                end
            end
        end
    end

    function automatic int next_delay();
        int d;
        d = LAT;
`ifdef BE_MEM_RAND_DELAY_EN
        d = LAT + int'(tb_lfsr[2:0]);
`endif
        tb_lfsr = {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
        return d;
    endfunction

    task automatic check_idle(input string name);
        total++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
            bad++;
            $display("FAIL %s got ready=%b rdata=%h want ready=0 rdata=0", name, mem_ready, mem_rdata);
        end
    endtask

    // Issue one request, then scramble inputs (valid kept high) until the response is seen.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rd);
        exp_t e;
        int   i;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        e.cyc = cyc + 2 + next_delay();
        if (s == 4'h0) last_rd = exp_rd;
        e.rdata = last_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        mem_addr = ~a; mem_wdata = ~d; mem_wstrb = ~s;
        i = 0;
        while (sb.size() != 0 && i < 64) begin
            @(posedge clk);
            i++;
        end
        #1 mem_valid = 1'b0;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout addr=%h got no ready want ready by cyc=%0d", a, e.cyc);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("in_reset");
        end
        reset = 1'b0;
        tb_lfsr = 8'hA5;
        last_rd = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        repeat (5) begin
            @(negedge clk);
            check_idle("post_reset_idle");
        end

        issue(32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        issue(32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        issue(32'h10, 32'h11223344, 4'b0101, 32'h0);
        issue(32'h10, 32'h0, 4'h0, 32'hDE22BE44);
        issue(32'h1000_0010, 32'h5A5A5A5A, 4'hF, 32'h0);
        issue(32'h10, 32'h0, 4'h0, 32'h5A5A5A5A);
        issue(32'h24, 32'h01020304, 4'hF, 32'h0);
        issue(32'h24, 32'hAABBCCDD, 4'b1000, 32'h0);
        issue(32'h24, 32'h0, 4'h0, 32'hAA020304);
        issue(32'h20, 32'h0, 4'hF, 32'h0);

        // Write accepted, then reset during WAIT: must be dropped with no response.
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hFFFFFFFF; mem_wstrb = 4'hF;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check_idle("after_abandon");
        issue(32'h20, 32'h0, 4'h0, 32'h0);

        // Delay sequence: 16 consecutive reads.
        for (int k = 0; k < 16; k++)
            issue(k[0] ? 32'h24 : 32'h10, 32'h0, 4'h0, k[0] ? 32'hAA020304 : 32'h5A5A5A5A);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
